// File: rtl/alu_op_decoder.sv
// Decode-to-execute stage: turns fetched instruction words into ALU op codes and control strobes.
// The registered ID/EX output has a one-entry skid buffer. DEC_STALL_CNT_EN adds a stall_cnt output.
module alu_op_decoder #(
    parameter int BIT_WIDTH = 32,
    parameter int OP_BITS   = 5,
    parameter int REG_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_BITS-1:0]   alu_op,
    output logic [REG_BITS-1:0]  rd,
    output logic [REG_BITS-1:0]  rs1,
    output logic [REG_BITS-1:0]  rs2,
    output logic [BIT_WIDTH-1:0] imm,
    output logic                 use_imm,
    output logic                 reg_wr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 is_branch,
    output logic                 is_jal,
`ifdef DEC_STALL_CNT_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic                 illegal
);

    localparam logic [3:0] FMT_ALU_R = 4'hC;
    localparam logic [3:0] FMT_ALU_I = 4'h4;
    localparam logic [3:0] FMT_CMP_R = 4'hD;
    localparam logic [3:0] FMT_CMP_I = 4'h5;
    localparam logic [3:0] FMT_LW    = 4'h7;
    localparam logic [3:0] FMT_SW    = 4'h3;
    localparam logic [3:0] FMT_BR    = 4'h2;
    localparam logic [3:0] FMT_JAL   = 4'hB;
    localparam logic [3:0] FN_MVHI   = 4'hB;

    localparam logic [OP_BITS-1:0] OP_MVHI     = OP_BITS'(5'd8);
    localparam logic [OP_BITS-1:0] OP_CMP_BASE = OP_BITS'(5'd9);

    typedef struct packed {
        logic [OP_BITS-1:0]   alu_op;
        logic [REG_BITS-1:0]  rd;
        logic [REG_BITS-1:0]  rs1;
        logic [REG_BITS-1:0]  rs2;
        logic [BIT_WIDTH-1:0] imm;
        logic                 use_imm;
        logic                 reg_wr;
        logic                 mem_rd;
        logic                 mem_wr;
        logic                 is_branch;
        logic                 is_jal;
        logic                 illegal;
    } payload_t;

    logic [3:0]  fmt_s;
    logic [3:0]  fn_s;
    logic [15:0] imm16_s;
    payload_t    dec_s;
    payload_t    main_r;
    payload_t    skid_r;
    logic        main_valid_r;
    logic        skid_valid_r;
    logic        in_ready_r;
    logic        in_fire_s;
    logic        out_fire_s;

    assign fmt_s      = in_inst[31:28];
    assign fn_s       = in_inst[27:24];
    assign imm16_s    = in_inst[15:0];
    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = main_valid_r && out_ready;

    // Combinational decode; illegal words leave alu_op and every strobe at zero.
    always_comb begin
        dec_s       = '0;
        dec_s.rd    = REG_BITS'(in_inst[23:20]);
        dec_s.rs1   = REG_BITS'(in_inst[19:16]);
        dec_s.rs2   = REG_BITS'(in_inst[15:12]);
        dec_s.imm   = {{(BIT_WIDTH-16){imm16_s[15]}}, imm16_s};
        case (fmt_s)
            FMT_ALU_R, FMT_ALU_I: begin
                if (!fn_s[3]) begin
                    dec_s.alu_op  = OP_BITS'(fn_s);
                    dec_s.reg_wr  = 1'b1;
                    dec_s.use_imm = (fmt_s == FMT_ALU_I);
                end else if ((fmt_s == FMT_ALU_I) && (fn_s == FN_MVHI)) begin
                    dec_s.alu_op  = OP_MVHI;
                    dec_s.imm     = {{(BIT_WIDTH-16){1'b0}}, imm16_s};
                    dec_s.reg_wr  = 1'b1;
                    dec_s.use_imm = 1'b1;
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            FMT_CMP_R, FMT_CMP_I, FMT_BR: begin
                if (!fn_s[3]) begin
                    dec_s.alu_op    = OP_BITS'(fn_s) + OP_CMP_BASE;
                    dec_s.is_branch = (fmt_s == FMT_BR);
                    dec_s.reg_wr    = (fmt_s != FMT_BR);
                    dec_s.use_imm   = (fmt_s == FMT_CMP_I);
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            FMT_LW, FMT_SW, FMT_JAL: begin
                if (!fn_s[3]) begin
                    dec_s.use_imm = 1'b1;
                    dec_s.mem_rd  = (fmt_s == FMT_LW);
                    dec_s.mem_wr  = (fmt_s == FMT_SW);
                    dec_s.is_jal  = (fmt_s == FMT_JAL);
                    dec_s.reg_wr  = (fmt_s == FMT_LW) || (fmt_s == FMT_JAL);
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
    end

    // Main/skid pipeline register; in_ready is tracked as its own flop mirroring !skid_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (skid_valid_r) begin
            if (out_fire_s) begin
                main_r       <= skid_r;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end
        end else if (in_fire_s) begin
            if (!main_valid_r || out_fire_s) begin
                main_r       <= dec_s;
                main_valid_r <= 1'b1;
            end else begin
                skid_r       <= dec_s;
                skid_valid_r <= 1'b1;
                in_ready_r   <= 1'b0;
            end
        end else if (out_fire_s) begin
            main_valid_r <= 1'b0;
        end
    end

`ifdef DEC_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Counts cycles where a valid result waits on execute; wraps naturally, flush leaves it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= 32'd0;
        end else if (main_valid_r && !out_ready) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign alu_op    = main_r.alu_op;
    assign rd        = main_r.rd;
    assign rs1       = main_r.rs1;
    assign rs2       = main_r.rs2;
    assign imm       = main_r.imm;
    assign use_imm   = main_r.use_imm;
    assign reg_wr    = main_r.reg_wr;
    assign mem_rd    = main_r.mem_rd;
    assign mem_wr    = main_r.mem_wr;
    assign is_branch = main_r.is_branch;
    assign is_jal    = main_r.is_jal;
    assign illegal   = main_r.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder: decode table, skid back-pressure, flush and illegal words.
module tb_alu_op_decoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_branch;
    logic        is_jal;
    logic        illegal;
`ifdef DEC_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_tests;
    int n_fail;

    logic [6:0] strobes;
    assign strobes = {use_imm, reg_wr, mem_rd, mem_wr, is_branch, is_jal, illegal};

    alu_op_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .use_imm   (use_imm),
        .reg_wr    (reg_wr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .is_branch (is_branch),
        .is_jal    (is_jal),
`ifdef DEC_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe order: {use_imm, reg_wr, mem_rd, mem_wr, is_branch, is_jal, illegal}
    logic [31:0] fmt_inst [8] = '{32'hC2AB_0000, 32'h4500_8000, 32'hD600_0000, 32'h5000_0007,
                                  32'h7012_0004, 32'h3012_0004, 32'hB100_0100, 32'hC700_0000};
    logic [4:0]  fmt_op   [8] = '{5'd2, 5'd5, 5'd15, 5'd9, 5'd0, 5'd0, 5'd0, 5'd7};
    logic [6:0]  fmt_stb  [8] = '{7'b0100000, 7'b1100000, 7'b0100000, 7'b1100000,
                                  7'b1110000, 7'b1001000, 7'b1100010, 7'b0100000};
    logic [31:0] fmt_imm  [8] = '{32'h0000_0000, 32'hFFFF_8000, 32'h0000_0000, 32'h0000_0007,
                                  32'h0000_0004, 32'h0000_0004, 32'h0000_0100, 32'h0000_0000};
    logic [31:0] ill_inst [5] = '{32'h9000_0000, 32'hC900_0000, 32'h2A12_FFF0, 32'h5B00_0000, 32'h7800_0000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_inst = 32'd0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (alu_op !== 5'd0 || imm !== 32'd0 || strobes !== 7'd0) begin
            n_fail++; $display("FAIL reset_payload got op=%0d imm=%h stb=%b want 0", alu_op, imm, strobes);
        end
        reset_n = 1'b1;
        step();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_mvhi();
        in_inst = 32'h4B30_1234; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || alu_op !== 5'd8) begin
            n_fail++; $display("FAIL mvhi_op got vld=%b op=%0d want 1/8", out_valid, alu_op);
        end
        n_tests++; if (imm !== 32'h0000_1234 || rd !== 4'd3) begin
            n_fail++; $display("FAIL mvhi_imm got imm=%h rd=%0d want 00001234/3", imm, rd);
        end
        n_tests++; if (strobes !== 7'b1100000) begin n_fail++; $display("FAIL mvhi_strobes got %b want 1100000", strobes); end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mvhi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_branch();
        in_inst = 32'h2712_FFF0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || alu_op !== 5'd16) begin
            n_fail++; $display("FAIL br_op got vld=%b op=%0d want 1/16", out_valid, alu_op);
        end
        n_tests++; if (imm !== 32'hFFFF_FFF0 || rd !== 4'd1 || rs1 !== 4'd2 || rs2 !== 4'hF) begin
            n_fail++; $display("FAIL br_fields got imm=%h rd=%0d rs1=%0d rs2=%0d want FFFFFFF0/1/2/15", imm, rd, rs1, rs2);
        end
        n_tests++; if (strobes !== 7'b0000100) begin n_fail++; $display("FAIL br_strobes got %b want 0000100", strobes); end
        step();
    endtask

    task automatic test_formats();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_inst = fmt_inst[i]; in_valid = 1'b1;
            step();
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_op !== fmt_op[i] || strobes !== fmt_stb[i] || imm !== fmt_imm[i]) begin
                n_fail++;
                $display("FAIL fmt_%0d got vld=%b rdy=%b op=%0d stb=%b imm=%h want 1/1/%0d/%b/%h",
                         i, out_valid, in_ready, alu_op, strobes, imm, fmt_op[i], fmt_stb[i], fmt_imm[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_inst = 32'hC000_0000; in_valid = 1'b1;
        step();
        n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_op !== 5'd0) begin
            n_fail++; $display("FAIL bp_first got vld=%b rdy=%b op=%0d want 1/1/0", out_valid, in_ready, alu_op);
        end
        in_inst = 32'hC100_0000;
        step();
        n_tests++; if (in_ready !== 1'b0 || alu_op !== 5'd0) begin
            n_fail++; $display("FAIL bp_skid got rdy=%b op=%0d want 0/0", in_ready, alu_op);
        end
        in_inst = 32'hC200_0000;
        step();
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_op !== 5'd0) begin
            n_fail++; $display("FAIL bp_hold got rdy=%b vld=%b op=%0d want 0/1/0", in_ready, out_valid, alu_op);
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_valid !== 1'b1 || alu_op !== 5'd1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_rel1 got vld=%b op=%0d rdy=%b want 1/1/1", out_valid, alu_op, in_ready);
        end
        step();
        n_tests++; if (out_valid !== 1'b1 || alu_op !== 5'd2) begin
            n_fail++; $display("FAIL bp_rel2 got vld=%b op=%0d want 1/2", out_valid, alu_op);
        end
        in_inst = 32'hC300_0000;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || alu_op !== 5'd3) begin
            n_fail++; $display("FAIL bp_rel3 got vld=%b op=%0d want 1/3", out_valid, alu_op);
        end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
`ifdef DEC_STALL_CNT_EN
        n_tests++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL bp_stall_cnt got %0d want 2", stall_cnt); end
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'hD000_0000;
        step();
        in_inst = 32'hD100_0000;
        step();
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_op !== 5'd9) begin
            n_fail++; $display("FAIL fl_full got rdy=%b vld=%b op=%0d want 0/1/9", in_ready, out_valid, alu_op);
        end
        in_inst = 32'hD700_0000; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL fl_both got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_skid_gone got %b want 0", out_valid); end
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hD200_0000;
        step();
        in_inst = 32'hD600_0000; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL fl_main got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_input_dropped got %b want 0", out_valid); end
`ifdef DEC_STALL_CNT_EN
        n_tests++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL fl_stall_cnt got %0d want 5", stall_cnt); end
`endif
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_inst = ill_inst[i]; in_valid = 1'b1;
            step();
            n_tests++;
            if (out_valid !== 1'b1 || alu_op !== 5'd0 || strobes !== 7'b0000001) begin
                n_fail++;
                $display("FAIL illegal_%0d got vld=%b op=%0d stb=%b want 1/0/0000001", i, out_valid, alu_op, strobes);
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_drain got %b want 0", out_valid); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_mvhi();
        test_branch();
        test_formats();
        test_back_pressure();
        test_flush();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
